// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types, constants and line decode for the I2C controller core
// Purpose: state encoding, quarter-phase indices, R/W encodings and the
//          per-phase SDA/SCL level table used by i2c_controller_core.
// Ports:   none (package).
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_RSTART,
        ST_STOP
    } i2c_state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

    // Returns {sda, scl} for a state and quarter phase; 1 = released.
    // Data/ACK bits keep SCL low in q0/q1 and high in q2/q3 (q[1]).
    function automatic logic [1:0] line_levels(input i2c_state_t st,
                                               input logic [1:0] q,
                                               input logic       tx_bit);
        logic [1:0] v;
        case (st)
            ST_IDLE:          v = 2'b11;
            ST_START:         v = {(q == Q0), (q <= Q1)};
            ST_RSTART:        v = {(q <= Q1), ((q == Q1) || (q == Q2))};
            ST_STOP:          v = {q[1], (q != Q0)};
            ST_ADDR, ST_WRITE: v = {tx_bit, q[1]};
            default:          v = {1'b1, q[1]};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/i2c_qphase_gen.sv
// rtl/i2c_qphase_gen.sv - quarter-phase tick and index generator
// Purpose: divides clk into quarter-bit phases while the controller is active.
// Ports:   clk, rst (async, active-high); i_run (hold at q0 when low);
//          o_tick (last clk of the current quarter phase); o_q (phase 0..3).
module i2c_qphase_gen
    import i2c_pkg::*;
#(
    parameter int QPHASE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    output logic       o_tick,
    output logic [1:0] o_q
);

    localparam int            CW       = (QPHASE_CYCLES > 1) ? $clog2(QPHASE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(QPHASE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;
    logic          w_last;

    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (!i_run) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_run & w_last;
    assign o_q    = r_q;

endmodule

// File: rtl/i2c_controller_core.sv
// rtl/i2c_controller_core.sv - single-master I2C byte engine
// Purpose: START, address+R/W, one data byte, ACK handling, STOP or repeated START.
// Ports:   clk, rst (async, active-high); enable (start, sampled in IDLE);
//          slave_address[6:0], data_in[7:0], rw, repeated_start_cond;
//          sda_in (pad level); sda_out/scl_out (0 = pull low, 1 = release);
//          data_out[7:0] (last read byte); busy; ack_error (sticky NACK).
module i2c_controller_core
    import i2c_pkg::*;
#(
    parameter int QPHASE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] slave_address,
    input  logic [7:0] data_in,
    input  logic       rw,
    input  logic       repeated_start_cond,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       scl_out,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       ack_error
);

    i2c_state_t r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_rw, w_rw_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic [7:0] r_data_out, w_data_out_nxt;
    logic       r_ack_error, w_ack_error_nxt;
    logic       r_sda, r_scl, r_busy;

    logic       w_tick;
    logic [1:0] w_q, w_q_nxt;
    logic       w_bit_end, w_sample;
    logic [1:0] w_lines_nxt;

    i2c_qphase_gen #(
        .QPHASE_CYCLES(QPHASE_CYCLES)
    ) u_qphase (
        .clk    (clk),
        .rst    (rst),
        .i_run  (r_state != ST_IDLE),
        .o_tick (w_tick),
        .o_q    (w_q)
    );

    assign w_bit_end = w_tick && (w_q == Q3);
    assign w_sample  = w_tick && (w_q == Q2);

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_rw_nxt        = r_rw;
        w_data_nxt      = r_data;
        w_data_out_nxt  = r_data_out;
        w_ack_error_nxt = r_ack_error;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt     = ST_START;
                    w_shift_nxt     = {slave_address, rw};
                    w_rw_nxt        = rw;
                    w_data_nxt      = data_in;
                    w_ack_error_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_ADDR;
                    w_bit_cnt_nxt = 3'd7;
                end
            end
            ST_ADDR, ST_WRITE: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_state_nxt = (r_state == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                    end else begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (w_sample && sda_in) begin
                    w_ack_error_nxt = 1'b1;
                end
                // The ACK was sampled in q2, so r_ack_error is current by q3.
                if (w_bit_end) begin
                    w_bit_cnt_nxt = 3'd7;
                    if (r_ack_error) begin
                        w_state_nxt = ST_STOP;
                    end else if (r_rw == I2C_READ) begin
                        w_state_nxt = ST_READ;
                    end else begin
                        w_state_nxt = ST_WRITE;
                        w_shift_nxt = r_data;
                    end
                end
            end
            ST_WRITE_ACK: begin
                if (w_sample && sda_in) begin
                    w_ack_error_nxt = 1'b1;
                end
                if (w_bit_end) begin
                    w_state_nxt = (repeated_start_cond && !r_ack_error) ? ST_RSTART : ST_STOP;
                end
            end
            ST_READ: begin
                if (w_sample) begin
                    w_shift_nxt = {r_shift[6:0], sda_in};
                    if (r_bit_cnt == 3'd0) begin
                        w_data_out_nxt = {r_shift[6:0], sda_in};
                    end
                end
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_state_nxt = ST_READ_ACK;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
            end
            ST_READ_ACK: begin
                if (w_bit_end) begin
                    w_state_nxt = (repeated_start_cond && !r_ack_error) ? ST_RSTART : ST_STOP;
                end
            end
            ST_RSTART: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_ADDR;
                    w_bit_cnt_nxt = 3'd7;
                    w_shift_nxt   = {slave_address, rw};
                    w_rw_nxt      = rw;
                    w_data_nxt    = data_in;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line levels are decoded from the next state/phase so the pad drivers
    // come straight from flops and line up with the phase they belong to.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_q_nxt = Q0;
        end else begin
            w_q_nxt = w_tick ? (w_q + 2'd1) : w_q;
        end
        w_lines_nxt = line_levels(w_state_nxt, w_q_nxt, w_shift_nxt[7]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rw        <= I2C_WRITE;
            r_data      <= '0;
            r_data_out  <= '0;
            r_ack_error <= 1'b0;
            r_sda       <= 1'b1;
            r_scl       <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_rw        <= w_rw_nxt;
            r_data      <= w_data_nxt;
            r_data_out  <= w_data_out_nxt;
            r_ack_error <= w_ack_error_nxt;
            r_sda       <= w_lines_nxt[1];
            r_scl       <= w_lines_nxt[0];
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sda_out   = r_sda;
    assign scl_out   = r_scl;
    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign ack_error = r_ack_error;

endmodule

// File: tb/tb_i2c_controller_core.sv
// tb/tb_i2c_controller_core.sv - scoreboard bench for i2c_controller_core
module tb_i2c_controller_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] slave_address = 7'h00;
    logic [7:0] data_in = 8'h00;
    logic       rw = 1'b0;
    logic       repeated_start_cond = 1'b0;
    logic       sda_in = 1'b1;
    logic       sda_out, scl_out, busy, ack_error;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    i2c_controller_core #(.QPHASE_CYCLES(1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .slave_address       (slave_address),
        .data_in             (data_in),
        .rw                  (rw),
        .repeated_start_cond (repeated_start_cond),
        .sda_in              (sda_in),
        .sda_out             (sda_out),
        .scl_out             (scl_out),
        .data_out            (data_out),
        .busy                (busy),
        .ack_error           (ack_error)
    );

    int checks = 0;
    int errors = 0;

    localparam int TOK_START = 32'h100;
    localparam int TOK_STOP  = 32'h200;
    localparam int TOK_BYTE  = 32'h1000;

    int exp_q[$];

    // Slave model configuration, written only while the DUT is idle.
    logic       mon_en = 1'b0;
    int         slv_addr_acks = 0;
    logic       slv_data_ack = 1'b0;
    logic [7:0] slv_rd_byte = 8'hFF;

    // Bus monitor / slave state.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       sda_b, scl_b;
    logic [8:0] mon_sh = '0;
    int         mon_bits = 0;
    int         mon_kind = 0;   // 0 address, 1 write data, 2 read data
    int         addr_frames = 0;
    logic       last_rw = 1'b0;
    logic       last_ack = 1'b1;
    int         tok, exp_tok;

    function automatic int tok_byte(input logic [7:0] b, input logic a);
        return TOK_BYTE + int'({b, a});
    endfunction

    always @(negedge clk) begin
        sda_b = sda_out & sda_in;
        scl_b = scl_out;
        tok   = -1;
        if (rst || !mon_en) begin
            sda_in   = 1'b1;
            mon_bits = 0;
            mon_kind = 0;
        end else begin
            if (sda_b !== prev_sda) begin
                checks++;
                if (!prev_scl && scl_b) begin
                    errors++;
                    $display("FAIL sda_legality: sda changed %b->%b on scl rise at %0t, required change only with scl low",
                             prev_sda, sda_b, $time);
                end
            end
            if (prev_scl && scl_b && prev_sda && !sda_b) begin
                tok      = TOK_START;
                mon_bits = 0;
                mon_kind = 0;
            end else if (prev_scl && scl_b && !prev_sda && sda_b) begin
                tok = TOK_STOP;
            end else if (!prev_scl && scl_b) begin
                mon_sh = {mon_sh[7:0], sda_b};
                mon_bits++;
                if (mon_bits == 9) begin
                    tok = TOK_BYTE + int'(mon_sh);
                    if (mon_kind == 0) begin
                        last_rw  = mon_sh[1];
                        last_ack = mon_sh[0];
                        addr_frames++;
                    end
                end
            end
            if (prev_scl && !scl_b) begin
                if (mon_bits == 9) begin
                    mon_kind = (mon_kind == 0 && !last_ack) ? (last_rw ? 2 : 1) : 1;
                    mon_bits = 0;
                end
                if (mon_kind == 2 && mon_bits < 8)
                    sda_in = slv_rd_byte[7 - mon_bits];
                else if (mon_bits == 8 && mon_kind == 0)
                    sda_in = (addr_frames < slv_addr_acks) ? 1'b0 : 1'b1;
                else if (mon_bits == 8 && mon_kind == 1)
                    sda_in = !slv_data_ack;
                else
                    sda_in = 1'b1;
            end
            if (tok != -1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_event: got token %0h at %0t, required none (queue empty)", tok, $time);
                end else begin
                    exp_tok = exp_q.pop_front();
                    if (tok !== exp_tok) begin
                        errors++;
                        $display("FAIL bus_event: got token %0h at %0t, required %0h", tok, $time, exp_tok);
                    end
                end
            end
        end
        prev_scl = scl_b;
        prev_sda = sda_b;
    end

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b required 1", sda_out); end
        if (scl_out !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b required 1", scl_out); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (ack_error !== 1'b0) begin errors++; $display("FAIL reset_ack_error: got %b required 0", ack_error); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h required 00", data_out); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sda_out !== 1'b1 || scl_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b sda=%b scl=%b required 0 1 1", busy, sda_out, scl_out);
        end
    endtask

    task automatic test_read_rstart();
        int cyc;
        slave_address = 7'h6B; rw = 1'b1; data_in = 8'h00; repeated_start_cond = 1'b1;
        slv_addr_acks = addr_frames + 1; slv_rd_byte = 8'hFF; slv_data_ack = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok_byte(8'hD7, 1'b0));
        exp_q.push_back(tok_byte(8'hFF, 1'b1));
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok_byte(8'hD7, 1'b1));
        exp_q.push_back(TOK_STOP);
        pulse_enable();
        wait_idle(cyc);
        repeated_start_cond = 1'b0;
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstart_events: %0d tokens left, required 0", exp_q.size()); end
        if (data_out !== 8'hFF) begin errors++; $display("FAIL rstart_data_out: got %h required FF", data_out); end
        if (ack_error !== 1'b1) begin errors++; $display("FAIL rstart_ack_error: got %b required 1", ack_error); end
        if (cyc != 120) begin errors++; $display("FAIL rstart_busy_len: got %0d required 120", cyc); end
        exp_q.delete();
    endtask

    task automatic test_write();
        int cyc;
        slave_address = 7'h50; rw = 1'b0; data_in = 8'hAA; repeated_start_cond = 1'b0;
        slv_addr_acks = addr_frames + 1; slv_data_ack = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok_byte(8'hA0, 1'b0));
        exp_q.push_back(tok_byte(8'hAA, 1'b0));
        exp_q.push_back(TOK_STOP);
        pulse_enable();
        wait_idle(cyc);
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL write_events: %0d tokens left, required 0", exp_q.size()); end
        if (ack_error !== 1'b0) begin errors++; $display("FAIL write_ack_error: got %b required 0", ack_error); end
        if (data_out !== 8'hFF) begin errors++; $display("FAIL write_data_out: got %h required FF", data_out); end
        if (cyc != 80) begin errors++; $display("FAIL write_busy_len: got %0d required 80", cyc); end
        exp_q.delete();
    endtask

    task automatic test_addr_nack();
        int cyc;
        slave_address = 7'h50; rw = 1'b0; data_in = 8'h33; repeated_start_cond = 1'b0;
        slv_addr_acks = addr_frames; slv_data_ack = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok_byte(8'hA0, 1'b1));
        exp_q.push_back(TOK_STOP);
        pulse_enable();
        wait_idle(cyc);
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL nack_events: %0d tokens left, required 0", exp_q.size()); end
        if (ack_error !== 1'b1) begin errors++; $display("FAIL nack_ack_error: got %b required 1", ack_error); end
        if (cyc != 44) begin errors++; $display("FAIL nack_busy_len: got %0d required 44", cyc); end
        exp_q.delete();
    endtask

    task automatic test_read_capture();
        int cyc;
        slave_address = 7'h21; rw = 1'b1; data_in = 8'h00; repeated_start_cond = 1'b0;
        slv_addr_acks = addr_frames + 1; slv_rd_byte = 8'h3C;
        mon_en = 1'b1;
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok_byte(8'h43, 1'b0));
        exp_q.push_back(tok_byte(8'h3C, 1'b1));
        exp_q.push_back(TOK_STOP);
        pulse_enable();
        wait_idle(cyc);
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL capture_events: %0d tokens left, required 0", exp_q.size()); end
        if (data_out !== 8'h3C) begin errors++; $display("FAIL capture_data_out: got %h required 3C", data_out); end
        if (ack_error !== 1'b0) begin errors++; $display("FAIL capture_ack_error: got %b required 0", ack_error); end
        if (cyc != 80) begin errors++; $display("FAIL capture_busy_len: got %0d required 80", cyc); end
        exp_q.delete();
    endtask

    task automatic test_enable_ignored();
        int   cyc;
        logic stayed_idle;
        slave_address = 7'h2A; rw = 1'b0; data_in = 8'h55; repeated_start_cond = 1'b0;
        slv_addr_acks = addr_frames + 1; slv_data_ack = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok_byte(8'h54, 1'b0));
        exp_q.push_back(tok_byte(8'h55, 1'b0));
        exp_q.push_back(TOK_STOP);
        pulse_enable();
        slave_address = 7'h7F; data_in = 8'h0F; rw = 1'b1;
        cyc = 0;
        while (busy && cyc < 400) begin
            cyc++;
            enable = ((cyc % 13) == 5);
            @(negedge clk);
        end
        enable = 1'b0;
        stayed_idle = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0) stayed_idle = 1'b0;
        end
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_events: %0d tokens left, required 0", exp_q.size()); end
        if (cyc != 80) begin errors++; $display("FAIL ignore_busy_len: got %0d required 80", cyc); end
        if (!stayed_idle) begin errors++; $display("FAIL ignore_restart: busy rose after frame, required stay 0"); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_byte();
        mon_en = 1'b0;
        slave_address = 7'h00; rw = 1'b0; data_in = 8'h00;
        pulse_enable();
        repeat (20) @(negedge clk);
        checks += 3;
        if (sda_out !== 1'b0) begin errors++; $display("FAIL midbyte_pre_sda: got %b required 0", sda_out); end
        if (scl_out !== 1'b0) begin errors++; $display("FAIL midbyte_pre_scl: got %b required 0", scl_out); end
        if (busy !== 1'b1) begin errors++; $display("FAIL midbyte_pre_busy: got %b required 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL midbyte_sda: got %b required 1", sda_out); end
        if (scl_out !== 1'b1) begin errors++; $display("FAIL midbyte_scl: got %b required 1", scl_out); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midbyte_busy: got %b required 0", busy); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL midbyte_data_out: got %h required 00", data_out); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sda_out !== 1'b1 || scl_out !== 1'b1) begin
            errors++;
            $display("FAIL midbyte_idle: busy=%b sda=%b scl=%b required 0 1 1", busy, sda_out, scl_out);
        end
    endtask

    initial begin
        test_reset();
        test_read_rstart();
        test_write();
        test_addr_nack();
        test_read_capture();
        test_enable_ignored();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
